// File: rtl/serial_capture_pkg.sv
// Shared types for the serial capture block: output buffer state encoding.
package serial_capture_pkg;

    // Output buffer occupancy; encoding is fixed so out_valid is simply the state bit.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

endpackage : serial_capture_pkg

// File: rtl/serial_capture_edge_detect.sv
// Two-flop input stage for the serial line with single-cycle rise/fall pulses.
module serial_capture_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic d_q,
    output logic rise,
    output logic fall
);

    logic sample_q, sample_d;
    logic prev_q, prev_d;

    // Next-state for the sample and previous-sample flops; runs every cycle regardless of en.
    always_comb begin
        sample_d = d;
        prev_d   = sample_q;
    end

    // Input stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sample_q <= sample_d;
            prev_q   <= prev_d;
        end
    end

    assign d_q  = sample_q;
    assign rise = sample_q & ~prev_q;
    assign fall = ~sample_q & prev_q;

endmodule : serial_capture_edge_detect

// File: rtl/serial_capture.sv
// Serial-to-parallel capture with edge pulses and a one-word valid/ready output buffer.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_EMPTY | no word held; out_ready ignored; completion loads out_data
//  ST_FULL  | out_data holds an unaccepted word; completion without
//           | out_ready drops the new word and sets sticky overflow
module serial_capture
    import serial_capture_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d,
    input  logic                     en,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     overflow,
    output logic                     rise,
    output logic                     fall,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic             d_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             overflow_q, overflow_d;
    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] candidate;
    logic             complete;

    serial_capture_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .d_q   (d_q),
        .rise  (rise),
        .fall  (fall)
    );

    // Shift register and bit counter; the word completes on the WIDTH-th enabled sample.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        complete  = 1'b0;
        candidate = MSB_FIRST ? {shreg_q[WIDTH-2:0], d_q} : {d_q, shreg_q[WIDTH-1:1]};
        if (en) begin
            shreg_d = candidate;
            if (bit_cnt_q == LAST_CNT) begin
                complete  = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    // Output buffer next-state: accept-and-refill in one cycle is allowed, refill without accept drops.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    state_d    = ST_FULL;
                    out_data_d = candidate;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (complete) begin
                        out_data_d = candidate;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (complete) begin
                    overflow_d = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Datapath and buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_EMPTY;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == ST_FULL);
    assign overflow  = overflow_q;
    assign bit_cnt   = bit_cnt_q;

endmodule : serial_capture

// File: tb/tb_serial_capture.sv
// Directed self-checking bench for serial_capture (MSB-first main DUT, LSB-first companion).
module tb_serial_capture;

    logic       clk = 1'b0;
    logic       reset, d, en, out_ready;
    logic [7:0] out_data, out_data_l;
    logic       out_valid, overflow, rise, fall;
    logic       out_valid_l, overflow_l, rise_l, fall_l;
    logic [2:0] bit_cnt, bit_cnt_l;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .d(d), .en(en), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .overflow(overflow),
        .rise(rise), .fall(fall), .bit_cnt(bit_cnt)
    );

    serial_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .d(d), .en(en), .out_ready(out_ready),
        .out_data(out_data_l), .out_valid(out_valid_l), .overflow(overflow_l),
        .rise(rise_l), .fall(fall_l), .bit_cnt(bit_cnt_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; d = 1'b0; en = 1'b0; out_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Puts w[hi] on d for one idle cycle, then samples w[hi..lo] with en=1, MSB of the range first.
    task automatic shift_bits(input logic [7:0] w, input int hi, input int lo,
                              input logic rdy_body, input logic rdy_last);
        d = w[hi]; en = 1'b0; out_ready = rdy_body;
        step();
        for (int i = hi; i >= lo; i--) begin
            d = (i > lo) ? w[i-1] : 1'b0;
            en = 1'b1;
            out_ready = (i == lo) ? rdy_last : rdy_body;
            step();
        end
        en = 1'b0;
        d = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; d = 1'b1; en = 1'b1; out_ready = 1'b0;
        repeat (3) step();
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL t1_out_data got %h exp 00", out_data); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_out_valid got %b exp 0", out_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL t1_overflow got %b exp 0", overflow); end
        tests++; if ({rise, fall} !== 2'b00) begin fails++; $display("FAIL t1_edges got %b exp 00", {rise, fall}); end
        tests++; if (bit_cnt !== 3'd0) begin fails++; $display("FAIL t1_bit_cnt got %0d exp 0", bit_cnt); end
        reset = 1'b0;
        step();
        tests++; if (rise !== 1'b1) begin fails++; $display("FAIL t1_rise_pulse got %b exp 1", rise); end
        step();
        tests++; if (rise !== 1'b0) begin fails++; $display("FAIL t1_rise_clear got %b exp 0", rise); end
    endtask

    task automatic test_word_assembly();
        do_reset();
        shift_bits(8'hB2, 7, 0, 1'b1, 1'b1);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t2_valid got %b exp 1", out_valid); end
        tests++; if (out_data !== 8'hB2) begin fails++; $display("FAIL t2_data got %h exp b2", out_data); end
        tests++; if (out_data_l !== 8'h4D) begin fails++; $display("FAIL t2_lsb_data got %h exp 4d", out_data_l); end
        tests++; if (bit_cnt !== 3'd0) begin fails++; $display("FAIL t2_bit_cnt got %0d exp 0", bit_cnt); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t2_valid_drop got %b exp 0", out_valid); end
        tests++; if (out_data !== 8'hB2) begin fails++; $display("FAIL t2_data_hold got %h exp b2", out_data); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        shift_bits(8'hA5, 7, 0, 1'b0, 1'b0);
        tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL t3_first_data got %h exp a5", out_data); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL t3_first_ovf got %b exp 0", overflow); end
        shift_bits(8'h3C, 7, 0, 1'b0, 1'b0);
        tests++; if (out_data !== 8'hA5) begin fails++; $display("FAIL t3_data_kept got %h exp a5", out_data); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t3_valid got %b exp 1", out_valid); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL t3_overflow got %b exp 1", overflow); end
        out_ready = 1'b1;
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t3_drain got %b exp 0", out_valid); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL t3_ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_accept_and_complete();
        do_reset();
        shift_bits(8'h0F, 7, 0, 1'b0, 1'b0);
        tests++; if (out_data !== 8'h0F) begin fails++; $display("FAIL t4_first_data got %h exp 0f", out_data); end
        shift_bits(8'hF0, 7, 0, 1'b0, 1'b1);
        tests++; if (out_data !== 8'hF0) begin fails++; $display("FAIL t4_data got %h exp f0", out_data); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t4_valid got %b exp 1", out_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL t4_overflow got %b exp 0", overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_edges_en_off();
        do_reset();
        shift_bits(8'hC5, 7, 5, 1'b0, 1'b0);
        step();
        tests++; if (bit_cnt !== 3'd3) begin fails++; $display("FAIL t5_partial_cnt got %0d exp 3", bit_cnt); end
        d = 1'b1; step();
        tests++; if ({rise, fall} !== 2'b10) begin fails++; $display("FAIL t5_short_rise got %b exp 10", {rise, fall}); end
        d = 1'b0; step();
        tests++; if ({rise, fall} !== 2'b01) begin fails++; $display("FAIL t5_short_fall got %b exp 01", {rise, fall}); end
        step();
        tests++; if ({rise, fall} !== 2'b00) begin fails++; $display("FAIL t5_quiet got %b exp 00", {rise, fall}); end
        d = 1'b1; step();
        tests++; if ({rise, fall} !== 2'b10) begin fails++; $display("FAIL t5_long_rise got %b exp 10", {rise, fall}); end
        step();
        tests++; if ({rise, fall} !== 2'b00) begin fails++; $display("FAIL t5_long_high got %b exp 00", {rise, fall}); end
        step();
        d = 1'b0; step();
        tests++; if ({rise, fall} !== 2'b01) begin fails++; $display("FAIL t5_long_fall got %b exp 01", {rise, fall}); end
        tests++; if (bit_cnt !== 3'd3) begin fails++; $display("FAIL t5_cnt_frozen got %0d exp 3", bit_cnt); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t5_no_word got %b exp 0", out_valid); end
        step();
        shift_bits(8'hC5, 4, 0, 1'b0, 1'b0);
        tests++; if (out_data !== 8'hC5) begin fails++; $display("FAIL t5_resumed_word got %h exp c5", out_data); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t5_resumed_valid got %b exp 1", out_valid); end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        shift_bits(8'hFF, 7, 3, 1'b0, 1'b0);
        tests++; if (bit_cnt !== 3'd5) begin fails++; $display("FAIL t6_partial_cnt got %0d exp 5", bit_cnt); end
        reset = 1'b1; step(); reset = 1'b0;
        tests++; if (bit_cnt !== 3'd0) begin fails++; $display("FAIL t6_cnt_cleared got %0d exp 0", bit_cnt); end
        shift_bits(8'h81, 7, 0, 1'b0, 1'b0);
        tests++; if (out_data !== 8'h81) begin fails++; $display("FAIL t6_data got %h exp 81", out_data); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t6_valid got %b exp 1", out_valid); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL t6_overflow got %b exp 0", overflow); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; d = 1'b0; en = 1'b0; out_ready = 1'b0;
        test_reset();
        test_word_assembly();
        test_back_pressure();
        test_accept_and_complete();
        test_edges_en_off();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_capture
